keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//  Drives the row lines of a 4x4 active-low matrix keypad and reads its column lines.
//  Each key press is turned into a debounced 4-bit key code plus a one-cycle strobe.
//  It is the scan-driving counterpart of the single-key input conditioning in the panel front end.
//  It sits between the board keypad pins and the control FSMs; the 50 MHz system clock domain is assumed throughout.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per row slot (1 ms at 50 MHz); must be >= 4
//  DEB_SCANS  3      consecutive identical frames needed to accept a press or a release; range 2..15
// PORTS
//  clk        in   1  system clock, rising edge
//  clr        in   1  asynchronous, active-low reset
//  col_n      in   4  keypad columns, active-low (board pull-ups), asynchronous to clk
//  row_n      out  4  keypad rows, active-low, exactly one row low at any time
//  key_code   out  4  last accepted key = row*4 + col (row 0 = row_n[0], col 0 = col_n[0])
//  key_valid  out  1  one-cycle pulse when a new key is accepted
//  key_held   out  1  high from acceptance until the release is debounced
// BEHAVIOUR
//  Reset (clr=0, async): row_n=4'b1110, key_code=0, key_valid=0, key_held=0;
//   all counters, the synchronizer and the FSM clear.
//  Input sync: col_n passes through 2 flops before any use.
//  Scan: a divider counts 0..SCAN_DIV-1.
//   - When the divider is at SCAN_DIV-1, the synced columns are sampled for the current row.
//   - The low row rotates on that same edge: 1110->1101->1011->0111->1110.
//   - One frame = 4 row slots = 4*SCAN_DIV cycles. The frame result is evaluated on the row-3 sample edge.
//  Frame result:
//   - NONE: no column low on any row.
//   - ONE(code): exactly one (row,col) low in the whole frame.
//   - MULTI: two or more keys low.
//  FSM, advancing only at frame ends (a frame counter cnt counts consecutive frames):
//   IDLE:    ONE(c) -> cand=c, cnt=1, go DEBOUNCE.
//            NONE or MULTI -> stay.
//   DEBOUNCE: ONE(c) with c==cand -> cnt++.
//              When cnt reaches DEB_SCANS -> key_code=cand, key_valid=1 for one cycle, key_held=1, go HELD.
//             ONE(c) with c!=cand -> cand=c, cnt=1.
//             NONE or MULTI -> go IDLE.
//   HELD:    NONE -> cnt=1, go RELEASE.
//            ONE or MULTI -> stay; a different key is ignored (no rollover).
//   RELEASE: NONE -> cnt++.
//             When cnt reaches DEB_SCANS -> key_held=0, go IDLE.
//            ONE or MULTI -> go HELD; key_held stays 1 and no new pulse is issued.
//  Latency: a key stable from the start of a frame is accepted at the end of frame DEB_SCANS.
//   A press landing mid-frame may cost one extra frame.
//  key_valid never fires twice for one press; key_code holds its value until the next acceptance.
//  MULTI is never accepted as a key; it resets a debounce in progress.
//  Reset mid-debounce or while HELD: all state and outputs return to reset values and no pulse is emitted.
//   Scanning restarts at row 0 after clr rises.
// TESTING (SCAN_DIV=4, DEB_SCANS=3, frame = 16 cycles)
//  1. Reset: hold clr=0 with col_n=4'b0000 -> row_n=1110, key_valid=0, key_held=0, key_code=0.
//     After release with col_n=1111, row_n rotates every 4 clk.
//  2. Press: pull col_n[1] low only while row_n[2]=0, stable -> exactly one key_valid pulse
//     within 64 cycles, key_code=9, key_held=1.
//  3. Bounce: toggle key 9 every 8 cycles for 48 cycles, then hold -> no pulse during bounce,
//     exactly one pulse after 3 stable frames.
//  4. Release: stop key 9 -> key_held falls after 3 empty frames; key_code stays 9; no extra pulse.
//     A 1-frame release glitch -> key_held stays 1.
//  5. Multi/rollover: keys 0 and 15 pressed together -> no pulse.
//     Key 5 held, then key 6 added and key 5 dropped -> no pulse until a full release.
//  6. Reset mid-op: clr=0 for 1 cycle after 2 debounce frames of key 3 -> outputs reset,
//     no pulse, then acceptance 3 full frames after clr rises.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with frame-based debounce
module keypad_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  state_t st;
  logic [DW-1:0] div;
  logic [1:0] row, acc_n, hit_n, tot_n, col;
  logic [3:0] c1, c2, hits, acc_code, tot_code, cand, cnt;
  logic [2:0] sum;
  logic tick, fend, one, none, deb_done;
  always_comb begin
    hits = ~c2;
    hit_n = hits == 4'd0 ? 2'd0 : (hits & (hits - 4'd1)) == 4'd0 ? 2'd1 : 2'd2;
    col = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
    sum = {1'b0, acc_n} + {1'b0, hit_n};
    tot_n = sum >= 3'd2 ? 2'd2 : sum[1:0];
    tot_code = acc_n == 2'd0 ? {row, col} : acc_code;
    tick = div == DW'(SCAN_DIV - 1);
    fend = tick && row == 2'd3;
    one = tot_n == 2'd1;
    none = tot_n == 2'd0;
    deb_done = cnt + 4'd1 == 4'(DEB_SCANS);
    row_n = ~(4'b0001 << row);
  end
  // Per-row hit counts saturate at 2 so a frame collapses to NONE / ONE / MULTI.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      c1 <= 4'hF;
      c2 <= 4'hF;
      div <= '0;
      row <= 2'd0;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
      cand <= 4'd0;
      cnt <= 4'd0;
      st <= IDLE;
      key_code <= 4'd0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      c1 <= col_n;
      c2 <= c1;
      key_valid <= 1'b0;
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        row <= row + 2'd1;
        acc_n <= fend ? 2'd0 : tot_n;
        acc_code <= fend ? 4'd0 : tot_code;
      end
      if (fend) begin
        case (st)
          IDLE: if (one) begin
            cand <= tot_code;
            cnt <= 4'd1;
            st <= DEBOUNCE;
          end
          DEBOUNCE: if (one && tot_code == cand) begin
            cnt <= cnt + 4'd1;
            if (deb_done) begin
              key_code <= cand;
              key_valid <= 1'b1;
              key_held <= 1'b1;
              st <= HELD;
            end
          end else if (one) begin
            cand <= tot_code;
            cnt <= 4'd1;
          end else st <= IDLE;
          HELD: if (none) begin
            cnt <= 4'd1;
            st <= RELEASE;
          end
          RELEASE: if (none) begin
            cnt <= cnt + 4'd1;
            if (deb_done) begin
              key_held <= 1'b0;
              st <= IDLE;
            end
          end else st <= HELD;
        endcase
      end
    end
  end
endmodule
